// File: rtl/ahblite_master_bridge.sv
// Valid/ready command port to AHB-Lite master: SINGLE NONSEQ transfers with
// pipelined address/data phases, one response per command, two-cycle ERROR cancel/retry.
module ahblite_master_bridge #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   logic        ap_vld_reg,     ap_vld_next;
   logic        dp_vld_reg,     dp_vld_next;
   logic        dp_write_reg,   dp_write_next;
   logic        retry_hold_reg, retry_hold_next;
   logic [31:0] ap_wdata_reg,   ap_wdata_next;
   logic [31:0] haddr_reg,      haddr_next;
   logic        hwrite_reg,     hwrite_next;
   logic [2:0]  hsize_reg,      hsize_next;
   logic [31:0] hwdata_reg,     hwdata_next;
   logic        rsp_valid_reg,  rsp_valid_next;
   logic [31:0] rsp_rdata_reg,  rsp_rdata_next;
   logic        rsp_err_reg,    rsp_err_next;

   logic accept;
   logic ap_done;
   logic dp_done;
   logic cancel;
   logic retry;

   assign cmd_ready = ~HRESET & ~retry_hold_reg & (~ap_vld_reg | HREADY);
   assign accept    = cmd_valid & cmd_ready;
   assign ap_done   = ap_vld_reg & HREADY;
   assign dp_done   = dp_vld_reg & HREADY;
   // First ERROR cycle with a transfer already in its address phase: pull it back.
   assign cancel    = dp_vld_reg & HRESP & ~HREADY & ap_vld_reg;
   // Errored data phase finishes; the held-back transfer goes out again.
   assign retry     = retry_hold_reg & HREADY;

   always_comb begin
      ap_vld_next     = ap_vld_reg;
      dp_vld_next     = dp_vld_reg;
      dp_write_next   = dp_write_reg;
      retry_hold_next = retry_hold_reg;
      ap_wdata_next   = ap_wdata_reg;
      haddr_next      = haddr_reg;
      hwrite_next     = hwrite_reg;
      hsize_next      = hsize_reg;
      hwdata_next     = hwdata_reg;
      rsp_valid_next  = 1'b0;
      rsp_rdata_next  = rsp_rdata_reg;
      rsp_err_next    = rsp_err_reg;

      if (accept) begin
         ap_vld_next   = 1'b1;
         haddr_next    = cmd_addr;
         hwrite_next   = cmd_write;
         hsize_next    = cmd_size;
         ap_wdata_next = cmd_wdata;
      end else if (ap_done || cancel) begin
         ap_vld_next = 1'b0;
      end else if (retry) begin
         ap_vld_next = 1'b1;
      end

      if (cancel) begin
         retry_hold_next = 1'b1;
      end else if (retry) begin
         retry_hold_next = 1'b0;
      end

      if (ap_done) begin
         dp_vld_next   = 1'b1;
         dp_write_next = hwrite_reg;
         if (hwrite_reg) begin
            hwdata_next = ap_wdata_reg;
         end
      end else if (dp_done) begin
         dp_vld_next = 1'b0;
      end

      if (dp_done) begin
         rsp_valid_next = 1'b1;
         rsp_err_next   = HRESP;
         rsp_rdata_next = dp_write_reg ? 32'h0 : HRDATA;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         ap_vld_reg     <= 1'b0;
         dp_vld_reg     <= 1'b0;
         dp_write_reg   <= 1'b0;
         retry_hold_reg <= 1'b0;
         ap_wdata_reg   <= 32'h0;
         haddr_reg      <= 32'h0;
         hwrite_reg     <= 1'b0;
         hsize_reg      <= 3'b000;
         hwdata_reg     <= 32'h0;
         rsp_valid_reg  <= 1'b0;
         rsp_rdata_reg  <= 32'h0;
         rsp_err_reg    <= 1'b0;
      end else begin
         ap_vld_reg     <= ap_vld_next;
         dp_vld_reg     <= dp_vld_next;
         dp_write_reg   <= dp_write_next;
         retry_hold_reg <= retry_hold_next;
         ap_wdata_reg   <= ap_wdata_next;
         haddr_reg      <= haddr_next;
         hwrite_reg     <= hwrite_next;
         hsize_reg      <= hsize_next;
         hwdata_reg     <= hwdata_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_rdata_reg  <= rsp_rdata_next;
         rsp_err_reg    <= rsp_err_next;
      end
   end

   // HTRANS is NONSEQ exactly while an address phase is on the bus.
   assign HTRANS    = {ap_vld_reg, 1'b0};
   assign HADDR     = haddr_reg;
   assign HWRITE    = hwrite_reg;
   assign HSIZE     = hsize_reg;
   assign HWDATA    = hwdata_reg;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign busy      = ap_vld_reg | dp_vld_reg | retry_hold_reg;

endmodule
